line_scroll_ctrl: RTL and testbench
===================================

// Module: line_scroll_ctrl
// PURPOSE
//  Game sequencer for the scrolling random line generator. Runs the
//  IDLE/LOAD/RUN/PAUSE/OVER game FSM and turns VGA frame ticks into 1-cycle
//  step pulses that advance the line generator.
//  Step rate speeds up with level. Tracks score and level; collision ends the game.
//  Sits between top-level button/VGA timing logic and line_generate (drives its en_i and reset_i).
// PARAMETERS
//  BASE_PERIOD      8    frames per step at level 0
//  MIN_PERIOD       1    floor on frames per step
//  STEPS_PER_LEVEL  64   steps between level increments
//  MAX_LEVEL        7    level saturation value
//  SCORE_W          16   score counter width
// PORTS
//  clk_i         in   1        system clock
//  reset_i       in   1        async active-low reset
//  start_i       in   1        1-cycle pulse, debounced start button
//  pause_i       in   1        1-cycle pulse, toggles RUN<->PAUSE
//  hit_i         in   1        level, collision detected this cycle
//  frame_tick_i  in   1        1-cycle pulse per VGA frame
//  step_o        out  1        1-cycle pulse, advance line generator
//  gen_rst_n_o   out  1        active-low clear to line generator
//  running_o     out  1        high in RUN
//  over_o        out  1        high in OVER
//  score_o       out  SCORE_W  steps survived, saturating
//  level_o       out  4        current level
// BEHAVIOUR
//  Reset: reset_i asynchronous, active-low; clock clk_i. In reset:
//   state=IDLE, step_o=0, gen_rst_n_o=0, running_o=0, over_o=0, score_o=0,
//   level_o=0, frame counter=0.
//  States (registered; all outputs registered, 1-cycle latency from the cause):
//   IDLE : gen_rst_n_o=0. start_i -> LOAD.
//   LOAD : exactly 1 cycle. gen_rst_n_o=0, score/level/frame counter cleared.
//          Next state RUN. gen_rst_n_o=1 from the first RUN cycle.
//   RUN  : count frame_tick_i. On a tick with count==period-1: step_o=1 next
//          cycle, count<=0, score+1 (saturates at all-ones), steps-in-level+1.
//          Steps-in-level reaching STEPS_PER_LEVEL -> level+1 (sat MAX_LEVEL),
//          steps-in-level<=0.
//          period = max(BASE_PERIOD-level, MIN_PERIOD), computed unsigned.
//          No underflow: compare before subtracting.
//   PAUSE: counters frozen, no step_o, gen_rst_n_o=1. pause_i -> RUN.
//   OVER : over_o=1, counters frozen, score/level held for display.
//          start_i -> LOAD.
//  Priority in RUN, same cycle: hit_i > pause_i > step.
//   - hit_i -> OVER; a step due that cycle is dropped, score not incremented.
//   - pause_i with a step due -> PAUSE; step dropped, count not advanced.
//  hit_i is ignored outside RUN. pause_i is ignored in IDLE/LOAD/OVER.
//  start_i is ignored in RUN/PAUSE.
//  level change takes effect on the period for the next comparison. A count
//  already >= new period-1 fires on the next tick.
//  Async reset mid-game returns to IDLE immediately. No partial step pulse.
// STRUCTURE
//  Package line_game_pkg: state enum (IDLE,LOAD,RUN,PAUSE,OVER, 3-bit),
//   LEVEL_W=4, default parameter constants shared with line_generate top.
//  Sub-module step_divider: frame counter + period compare. Inputs en, clr,
//   tick, period; output step pulse.
//  FSM, score and level counters stay in line_scroll_ctrl.
// TESTING
//  1 reset release, start_i pulse -> one LOAD cycle with gen_rst_n_o=0, then
//    RUN, running_o=1, score_o=0.
//  2 RUN level 0, 16 frame ticks -> exactly 2 step_o pulses, each 1 cycle,
//    score_o=2.
//  3 STEPS_PER_LEVEL=4: after 4 steps level_o=1, next step needs 7 ticks.
//    At level 7 period stays 1 and level_o stays 7.
//  4 hit_i on the same cycle as a due tick -> no step_o, over_o=1,
//    score_o unchanged. Later start_i -> score_o=0, level_o=0.
//  5 pause_i mid-count 3 -> ticks ignored. pause_i again -> step after 5 more ticks.
//  6 reset_i low during RUN with score 10 -> outputs at reset values within
//    the same cycle, state IDLE.

Source files
------------

// File: rtl/line_scroll_ctrl_pkg.sv
// Shared definitions for the scrolling line game: FSM state encoding,
// level/period widths, default tuning constants and the step period rule.
package line_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } game_state_t;

  localparam int LEVEL_W             = 4;
  localparam int PERIOD_W            = 8;
  localparam int DEF_BASE_PERIOD     = 8;
  localparam int DEF_MIN_PERIOD      = 1;
  localparam int DEF_STEPS_PER_LEVEL = 64;
  localparam int DEF_MAX_LEVEL       = 7;
  localparam int DEF_SCORE_W         = 16;

  // Frames per step: base minus level, floored at min_p; compared first so it never wraps.
  function automatic logic [PERIOD_W-1:0] calc_period(input logic [LEVEL_W-1:0] level,
                                                      input int base, input int min_p);
    int lvl;
    lvl = int'(level);
    if (base > lvl + min_p) begin
      return PERIOD_W'(base - lvl);
    end else begin
      return PERIOD_W'(min_p);
    end
  endfunction

endpackage

// File: rtl/line_scroll_ctrl_step_divider.sv
// Frame tick divider: counts enabled ticks and flags the tick that completes a period.
module step_divider
  import line_game_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                tick_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                step_o
);

  logic [PERIOD_W-1:0] r_count;
  logic                w_period_done;

  // count >= period-1, rearranged so a period of zero cannot underflow
  assign w_period_done = ((PERIOD_W+1)'(r_count) + (PERIOD_W+1)'(1)) >= (PERIOD_W+1)'(period_i);
  assign step_o        = en_i & tick_i & w_period_done;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && tick_i) begin
      r_count <= w_period_done ? '0 : r_count + PERIOD_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/line_scroll_ctrl.sv
// Game sequencer: IDLE/LOAD/RUN/PAUSE/OVER FSM, score and level tracking,
// and step pulses for line_generate derived from VGA frame ticks.
module line_scroll_ctrl
  import line_game_pkg::*;
#(
  parameter int BASE_PERIOD     = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
  parameter int STEPS_PER_LEVEL = DEF_STEPS_PER_LEVEL,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int SCORE_W         = DEF_SCORE_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               hit_i,
  input  logic               frame_tick_i,
  output logic               step_o,
  output logic               gen_rst_n_o,
  output logic               running_o,
  output logic               over_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int SIL_W = $clog2(STEPS_PER_LEVEL + 1);

  game_state_t         r_state;
  logic                r_step;
  logic                r_gen_rst_n;
  logic                r_running;
  logic                r_over;
  logic [SCORE_W-1:0]  r_score;
  logic [LEVEL_W-1:0]  r_level;
  logic [SIL_W-1:0]    r_sil;

  logic                w_start_ok;
  logic                w_run_en;
  logic                w_due;
  logic [PERIOD_W-1:0] w_period;

  // hit and pause both suppress the divider, which drops any step due that cycle
  assign w_start_ok = start_i & ((r_state == S_IDLE) | (r_state == S_OVER));
  assign w_run_en   = (r_state == S_RUN) & ~hit_i & ~pause_i;
  assign w_period   = calc_period(r_level, BASE_PERIOD, MIN_PERIOD);

  step_divider u_step_divider (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (w_run_en),
    .clr_i    (w_start_ok),
    .tick_i   (frame_tick_i),
    .period_i (w_period),
    .step_o   (w_due)
  );

  // Game FSM with outputs registered from the state being entered
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_gen_rst_n <= 1'b0;
      r_running   <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= start_i ? S_LOAD : S_IDLE;
          r_gen_rst_n <= 1'b0;
          r_running   <= 1'b0;
          r_over      <= 1'b0;
        end
        S_LOAD: begin
          r_state     <= S_RUN;
          r_gen_rst_n <= 1'b1;
          r_running   <= 1'b1;
          r_over      <= 1'b0;
        end
        S_RUN: begin
          r_gen_rst_n <= 1'b1;
          if (hit_i) begin
            r_state   <= S_OVER;
            r_running <= 1'b0;
            r_over    <= 1'b1;
          end else if (pause_i) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
            r_over    <= 1'b0;
          end else begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_over    <= 1'b0;
          end
        end
        S_PAUSE: begin
          r_state     <= pause_i ? S_RUN : S_PAUSE;
          r_gen_rst_n <= 1'b1;
          r_running   <= pause_i;
          r_over      <= 1'b0;
        end
        S_OVER: begin
          r_state     <= start_i ? S_LOAD : S_OVER;
          r_gen_rst_n <= ~start_i;
          r_running   <= 1'b0;
          r_over      <= ~start_i;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gen_rst_n <= 1'b0;
          r_running   <= 1'b0;
          r_over      <= 1'b0;
        end
      endcase
    end
  end

  // Step pulse, saturating score and level progression
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_step  <= 1'b0;
      r_score <= '0;
      r_level <= '0;
      r_sil   <= '0;
    end else begin
      r_step <= w_due;
      if (w_start_ok) begin
        r_score <= '0;
        r_level <= '0;
        r_sil   <= '0;
      end else if (w_due) begin
        if (r_score != {SCORE_W{1'b1}}) begin
          r_score <= r_score + SCORE_W'(1);
        end else begin
          r_score <= r_score;
        end
        if (r_sil == SIL_W'(STEPS_PER_LEVEL - 1)) begin
          r_sil <= '0;
          if (r_level < LEVEL_W'(MAX_LEVEL)) begin
            r_level <= r_level + LEVEL_W'(1);
          end else begin
            r_level <= r_level;
          end
        end else begin
          r_sil <= r_sil + SIL_W'(1);
        end
      end else begin
        r_score <= r_score;
        r_level <= r_level;
        r_sil   <= r_sil;
      end
    end
  end

  assign step_o      = r_step;
  assign gen_rst_n_o = r_gen_rst_n;
  assign running_o   = r_running;
  assign over_o      = r_over;
  assign score_o     = r_score;
  assign level_o     = r_level;

endmodule

// File: tb/tb_line_scroll_ctrl.sv
// Bench for line_scroll_ctrl: directed game scenarios plus random play,
// checked every cycle against a behavioural game model.
module tb_line_scroll_ctrl;

  localparam int BASE = 8;
  localparam int MINP = 1;
  localparam int SPL  = 4;
  localparam int MAXL = 7;
  localparam int SMAX = 65535;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_OVER = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        pause_i = 1'b0;
  logic        hit_i = 1'b0;
  logic        frame_tick_i = 1'b0;
  logic        step_o, gen_rst_n_o, running_o, over_o;
  logic [15:0] score_o;
  logic [3:0]  level_o;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_fc, m_score, m_level, m_sil, m_step;

  line_scroll_ctrl #(
    .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .STEPS_PER_LEVEL(SPL),
    .MAX_LEVEL(MAXL), .SCORE_W(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i),
    .hit_i(hit_i), .frame_tick_i(frame_tick_i), .step_o(step_o),
    .gen_rst_n_o(gen_rst_n_o), .running_o(running_o), .over_o(over_o),
    .score_o(score_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_fc = 0; m_score = 0; m_level = 0; m_sil = 0; m_step = 0;
  endtask

  task automatic model_new_game();
    m_mode = M_LOAD; m_fc = 0; m_score = 0; m_level = 0; m_sil = 0;
  endtask

  // Advance the game model by one clock given this cycle's inputs
  task automatic model_predict(input bit s, input bit p, input bit h, input bit t);
    int period;
    m_step = 0;
    period = BASE - m_level;
    if (period < MINP) period = MINP;
    case (m_mode)
      M_IDLE:  if (s) model_new_game();
      M_LOAD:  m_mode = M_RUN;
      M_RUN: begin
        if (h) m_mode = M_OVER;
        else if (p) m_mode = M_PAUSE;
        else if (t) begin
          if (m_fc + 1 >= period) begin
            m_step = 1;
            m_fc = 0;
            if (m_score < SMAX) m_score++;
            m_sil++;
            if (m_sil == SPL) begin
              m_sil = 0;
              if (m_level < MAXL) m_level++;
            end
          end else begin
            m_fc++;
          end
        end
      end
      M_PAUSE: if (p) m_mode = M_RUN;
      M_OVER:  if (s) model_new_game();
      default: model_reset();
    endcase
  endtask

  // Per-cycle comparison of every output against the model
  always begin
    @(posedge clk_i);
    #1;
    chk("step_o", int'(step_o), m_step);
    chk("running_o", int'(running_o), int'(m_mode == M_RUN));
    chk("over_o", int'(over_o), int'(m_mode == M_OVER));
    chk("gen_rst_n_o", int'(gen_rst_n_o), int'(m_mode != M_IDLE && m_mode != M_LOAD));
    chk("score_o", int'(score_o), m_score);
    chk("level_o", int'(level_o), m_level);
  end

  // One clock: drive inputs at negedge, predict, return just after the edge
  task automatic cyc(input bit s, input bit p, input bit h, input bit t);
    @(negedge clk_i);
    start_i = s; pause_i = p; hit_i = h; frame_tick_i = t;
    model_predict(s, p, h, t);
    @(posedge clk_i);
    #2;
  endtask

  task automatic ticks(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      pulses += int'(step_o);
    end
  endtask

  initial begin
    int pulses, sc, guard;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_gen_rst_n", int'(gen_rst_n_o), 0);
    chk("rst_score", int'(score_o), 0);
    reset_i = 1'b1;

    // reset release, start -> one LOAD cycle, then RUN
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_gen_rst_n", int'(gen_rst_n_o), 0);
    chk("load_running", int'(running_o), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_running", int'(running_o), 1);
    chk("run_gen_rst_n", int'(gen_rst_n_o), 1);
    chk("run_score", int'(score_o), 0);

    // level 0: 16 ticks -> 2 steps
    ticks(16, pulses);
    chk("l0_pulses", pulses, 2);
    chk("l0_score", int'(score_o), 2);

    // two more steps -> level 1, then period 7
    ticks(16, pulses);
    chk("l1_level", int'(level_o), 1);
    chk("l1_score", int'(score_o), 4);
    ticks(6, pulses);
    chk("l1_6ticks", pulses, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("l1_7th_tick", int'(step_o), 1);

    guard = 0;
    while (level_o != 4'd7 && guard < 300) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("reach_level7", int'(level_o), 7);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("l7_every_tick", int'(step_o), 1);
    end
    chk("l7_saturated", int'(level_o), 7);

    // hit on a due tick
    sc = int'(score_o);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hit_step", int'(step_o), 0);
    chk("hit_over", int'(over_o), 1);
    chk("hit_score", int'(score_o), sc);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_score", int'(score_o), 0);
    chk("restart_level", int'(level_o), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // pause at count 3
    ticks(3, pulses);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pause_running", int'(running_o), 0);
    ticks(10, pulses);
    chk("pause_no_steps", pulses, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume_running", int'(running_o), 1);
    ticks(4, pulses);
    chk("resume_4ticks", pulses, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_5th_tick", int'(step_o), 1);
    chk("resume_score", int'(score_o), 1);

    // random play against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(19) == 0), ($urandom_range(59) == 0),
          ($urandom_range(299) == 0), ($urandom_range(2) == 0));
    end

    // fresh game to score 10, then async reset mid-cycle
    @(negedge clk_i);
    reset_i = 1'b0;
    start_i = 1'b0; pause_i = 1'b0; hit_i = 1'b0; frame_tick_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (score_o != 16'd10 && guard < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("score_reached_10", int'(score_o), 10);
    reset_i = 1'b0;
    #1;
    model_reset();
    chk("arst_step", int'(step_o), 0);
    chk("arst_gen_rst_n", int'(gen_rst_n_o), 0);
    chk("arst_running", int'(running_o), 0);
    chk("arst_over", int'(over_o), 0);
    chk("arst_score", int'(score_o), 0);
    chk("arst_level", int'(level_o), 0);
    @(negedge clk_i);
    start_i = 1'b0; frame_tick_i = 1'b0;
    reset_i = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_idle_running", int'(running_o), 0);
    chk("post_rst_idle_gen", int'(gen_rst_n_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
